// File: rtl/dm_pkg.sv
// -----------------------------------------------------------------------------
// dm_pkg -- shared definitions for the data memory and its controller.
//
// Holds the mem_op encodings driven by the controller, the datapath width
// constants, and small helpers that classify an access by size and
// signedness. Reserved mem_op values (101..111) classify as word accesses.
// -----------------------------------------------------------------------------
package dm_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 3;

    // mem_op encodings
    localparam logic [OP_W-1:0] MEM_W  = 3'b000;
    localparam logic [OP_W-1:0] MEM_HU = 3'b001;
    localparam logic [OP_W-1:0] MEM_H  = 3'b010;
    localparam logic [OP_W-1:0] MEM_BU = 3'b011;
    localparam logic [OP_W-1:0] MEM_B  = 3'b100;

    typedef enum logic [1:0] {
        SZ_WORD = 2'd0,
        SZ_HALF = 2'd1,
        SZ_BYTE = 2'd2
    } acc_size_e;

    function automatic acc_size_e op_size(input logic [OP_W-1:0] op);
        case (op)
            MEM_HU, MEM_H: op_size = SZ_HALF;
            MEM_BU, MEM_B: op_size = SZ_BYTE;
            default:       op_size = SZ_WORD;
        endcase
    endfunction

    function automatic logic op_signed(input logic [OP_W-1:0] op);
        op_signed = (op == MEM_H) || (op == MEM_B);
    endfunction

endpackage

// File: rtl/dm_ext.sv
// -----------------------------------------------------------------------------
// dm_ext -- load lane select and sign/zero extension (purely combinational).
//
// Ports:
//   i_word   [31:0]  full memory word at the addressed index
//   i_lane   [1:0]   addr[1:0]; byte lane, bit 1 doubles as half lane
//   i_mem_op [2:0]   access type (dm_pkg encoding)
//   o_rd     [31:0]  extended load data
// -----------------------------------------------------------------------------
module dm_ext
    import dm_pkg::*;
(
    input  logic [DATA_W-1:0] i_word,
    input  logic [1:0]        i_lane,
    input  logic [OP_W-1:0]   i_mem_op,
    output logic [DATA_W-1:0] o_rd
);

    logic [15:0] w_half;
    logic [7:0]  w_byte;
    logic        w_sext;

    assign w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
    assign w_byte = i_word[{i_lane, 3'b000} +: 8];
    assign w_sext = op_signed(i_mem_op);

    always_comb begin
        o_rd = i_word;
        case (op_size(i_mem_op))
            SZ_HALF: o_rd = {{16{w_sext & w_half[15]}}, w_half};
            SZ_BYTE: o_rd = {{24{w_sext & w_byte[7]}}, w_byte};
            default: o_rd = i_word;
        endcase
    end

endmodule

// File: rtl/dm.sv
// -----------------------------------------------------------------------------
// dm -- data memory for the single-cycle datapath.
//
// Byte-addressed, word-organised memory. Reads are combinational; stores
// commit on the rising clock edge as a read-modify-write of the addressed word.
// A synchronous reset clears every word in one edge and overrides any store.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words (power of two)
//   ADDR_BASE    byte address mapped to word 0
//
// Ports:
//   clk       system clock
//   reset     synchronous, active-high; clears the array
//   pc        PC of the current instruction (write trace only)
//   addr      byte address (ALU result)
//   wd        store data (GRF rt value)
//   we        store enable
//   mem_op    access type (dm_pkg encoding)
//   rd        extended load data; 0 when addr_err
//   addr_err  access is misaligned or out of range
//
// Optional: define DM_TRACE_EN to print "@pc: *addr <= word" for every
// committed store.
// -----------------------------------------------------------------------------
module dm
    import dm_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       pc,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wd,
    input  logic              we,
    input  logic [OP_W-1:0]   mem_op,
    output logic [DATA_W-1:0] rd,
    output logic              addr_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN_BYTES = 33'(4 * DEPTH_WORDS);

    logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

    logic [31:0]       w_off;
    logic              w_in_range;
    logic              w_misaligned;
    logic [AW-1:0]     w_idx;
    logic [DATA_W-1:0] w_word;
    logic [DATA_W-1:0] w_ext_rd;
    logic [DATA_W-1:0] w_merged;
    logic              w_commit;

    // Addresses below the base wrap to huge offsets, so a single unsigned
    // compare rejects both sides without aliasing.
    assign w_off      = addr - ADDR_BASE;
    assign w_in_range = ({1'b0, w_off} < SPAN_BYTES);
    assign w_idx      = w_off[AW+1:2];
    assign w_word     = r_mem[w_idx];

    always_comb begin
        w_misaligned = 1'b0;
        case (op_size(mem_op))
            SZ_HALF: w_misaligned = addr[0];
            SZ_BYTE: w_misaligned = 1'b0;
            default: w_misaligned = (addr[1:0] != 2'b00);
        endcase
    end

    assign addr_err = !w_in_range || w_misaligned;

    dm_ext u_ext (
        .i_word   (w_word),
        .i_lane   (addr[1:0]),
        .i_mem_op (mem_op),
        .o_rd     (w_ext_rd)
    );

    assign rd = addr_err ? '0 : w_ext_rd;

    // Store data merged into the current word; HU/BU stores act as H/B.
    always_comb begin
        w_merged = w_word;
        case (op_size(mem_op))
            SZ_HALF: w_merged[{addr[1], 4'b0000} +: 16] = wd[15:0];
            SZ_BYTE: w_merged[{addr[1:0], 3'b000} +: 8] = wd[7:0];
            default: w_merged = wd;
        endcase
    end

    assign w_commit = we && !addr_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_commit) begin
            r_mem[w_idx] <= w_merged;
        end
    end

`ifdef DM_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset && w_commit) begin
            $display("@%h: *%h <= %h", pc, {addr[31:2], 2'b00}, w_merged);
        end
    end
`else
    // pc only feeds the trace.
    logic w_unused_pc;
    assign w_unused_pc = ^pc;
`endif

endmodule

// File: tb/tb_dm.sv
// -----------------------------------------------------------------------------
// tb_dm -- self-checking bench for dm (DEPTH_WORDS=1024, ADDR_BASE=0).
// -----------------------------------------------------------------------------
module tb_dm;
    import dm_pkg::*;

    localparam int DEPTH = 1024;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        we;
    logic [2:0]  mem_op;
    logic [31:0] rd;
    logic        addr_err;

    dm #(.DEPTH_WORDS(DEPTH), .ADDR_BASE(32'h0000_0000)) dut (
        .clk      (clk),
        .reset    (reset),
        .pc       (pc),
        .addr     (addr),
        .wd       (wd),
        .we       (we),
        .mem_op   (mem_op),
        .rd       (rd),
        .addr_err (addr_err)
    );

    // ---------------- reference model ----------------
    logic [31:0] model_mem [DEPTH];
    logic [31:0] exp_q [$];
    int n_checks = 0;
    int n_errors = 0;

    // 0 = word, 1 = half, 2 = byte
    function automatic int model_size(input logic [2:0] op);
        if (op == 3'd1 || op == 3'd2) return 1;
        if (op == 3'd3 || op == 3'd4) return 2;
        return 0;
    endfunction

    function automatic logic model_err(input logic [2:0] op, input logic [31:0] a);
        if (a >= 32'(4 * DEPTH)) return 1'b1;
        case (model_size(op))
            0:       return (a % 4) != 0;
            1:       return (a % 2) != 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] op, input logic [31:0] a);
        logic [31:0] word;
        logic [31:0] v;
        if (model_err(op, a)) return 32'h0;
        word = model_mem[a[11:2]];
        case (op)
            3'd1: return (word >> (16 * ((a / 2) % 2))) & 32'hFFFF;
            3'd2: begin
                v = (word >> (16 * ((a / 2) % 2))) & 32'hFFFF;
                if (v >= 32'h8000) v = v - 32'h10000;
                return v;
            end
            3'd3: return (word >> (8 * (a % 4))) & 32'hFF;
            3'd4: begin
                v = (word >> (8 * (a % 4))) & 32'hFF;
                if (v >= 32'h80) v = v - 32'h100;
                return v;
            end
            default: return word;
        endcase
    endfunction

    function automatic void model_write(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] d);
        logic [31:0] mask;
        logic [31:0] sh;
        case (model_size(op))
            0: model_mem[a[11:2]] = d;
            1: begin
                sh   = 16 * ((a / 2) % 2);
                mask = 32'hFFFF << sh;
                model_mem[a[11:2]] = (model_mem[a[11:2]] & ~mask) | ((d & 32'hFFFF) << sh);
            end
            default: begin
                sh   = 8 * (a % 4);
                mask = 32'hFF << sh;
                model_mem[a[11:2]] = (model_mem[a[11:2]] & ~mask) | ((d & 32'hFF) << sh);
            end
        endcase
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // Called just after a posedge; reset is applied across exactly one edge.
    task automatic do_reset(input logic w, input logic [31:0] a, input logic [31:0] d);
        reset  = 1'b1;
        we     = w;
        mem_op = MEM_W;
        addr   = a;
        wd     = d;
        @(posedge clk);
        #1;
        reset = 1'b0;
        we    = 1'b0;
        foreach (model_mem[i]) model_mem[i] = 32'h0;
    endtask

    // One cycle of access: outputs are checked against the model at the
    // negedge (old contents), then the model takes the store after the posedge.
    task automatic access(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] d, input logic w);
        logic        exp_err;
        mem_op = op;
        addr   = a;
        wd     = d;
        we     = w;
        pc     = pc + 32'd4;
        @(negedge clk);
        exp_err = model_err(op, a);
        exp_q.push_back(model_read(op, a));
        check({tag, "_err"}, {31'b0, addr_err}, {31'b0, exp_err});
        check({tag, "_rd"}, rd, exp_q.pop_front());
        @(posedge clk);
        if (w && !exp_err) model_write(op, a, d);
        #1;
        we = 1'b0;
    endtask

    // Read with a fixed expected value taken from hand-worked examples.
    task automatic read_const(input string tag, input logic [2:0] op, input logic [31:0] a,
                              input logic [31:0] exp_rd, input logic exp_err);
        mem_op = op;
        addr   = a;
        we     = 1'b0;
        @(negedge clk);
        check({tag, "_rd"}, rd, exp_rd);
        check({tag, "_err"}, {31'b0, addr_err}, {31'b0, exp_err});
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [2:0]  r_op;
        logic [31:0] r_addr;
        int          sel;

        reset  = 1'b1;
        pc     = 32'h0000_3000;
        addr   = 32'h0;
        wd     = 32'h0;
        we     = 1'b0;
        mem_op = MEM_W;

        do_reset(1'b0, 32'h0, 32'h0);

        // reset then read
        read_const("rst_0",   MEM_W, 32'h0,   32'h0, 1'b0);
        read_const("rst_10",  MEM_W, 32'h10,  32'h0, 1'b0);
        read_const("rst_ffc", MEM_W, 32'hFFC, 32'h0, 1'b0);

        // word write then read
        access("sw8", MEM_W, 32'h8, 32'h1234_5678, 1'b1);
        read_const("lw8", MEM_W, 32'h8, 32'h1234_5678, 1'b0);

        // byte and half merge
        access("sb_b", MEM_B, 32'hB, 32'h0000_00AA, 1'b1);
        access("sh_8", MEM_H, 32'h8, 32'h0000_BEEF, 1'b1);
        read_const("mrg_w",  MEM_W,  32'h8, 32'hAA34_BEEF, 1'b0);
        read_const("mrg_b",  MEM_B,  32'hB, 32'hFFFF_FFAA, 1'b0);
        read_const("mrg_bu", MEM_BU, 32'hB, 32'h0000_00AA, 1'b0);
        read_const("mrg_h",  MEM_H,  32'h8, 32'hFFFF_BEEF, 1'b0);
        read_const("mrg_hu", MEM_HU, 32'h8, 32'h0000_BEEF, 1'b0);
        read_const("mrg_hi", MEM_H,  32'hA, 32'hFFFF_AA34, 1'b0);

        // misaligned stores are suppressed
        access("sw6", MEM_W, 32'h6, 32'hFFFF_FFFF, 1'b1);
        access("sh9", MEM_H, 32'h9, 32'hFFFF_FFFF, 1'b1);
        read_const("mis_w4", MEM_W, 32'h4, 32'h0, 1'b0);
        read_const("mis_w8", MEM_W, 32'h8, 32'hAA34_BEEF, 1'b0);
        read_const("mis_hu", MEM_HU, 32'h3, 32'h0, 1'b1);

        // out of range must not alias word 0
        access("oor_1000", MEM_W, 32'h1000, 32'hCAFE_F00D, 1'b1);
        access("oor_neg",  MEM_B, 32'hFFFF_FFFC, 32'h5A, 1'b1);
        read_const("oor_w0", MEM_W, 32'h0, 32'h0, 1'b0);
        read_const("top_b",  MEM_BU, 32'hFFF, 32'h0, 1'b0);

        // reset wins over a simultaneous store
        do_reset(1'b1, 32'h4, 32'hDEAD_BEEF);
        read_const("rw_4", MEM_W, 32'h4, 32'h0, 1'b0);
        read_const("rw_8", MEM_W, 32'h8, 32'h0, 1'b0);

        // randomized traffic, concentrated on a small window plus the edges
        for (int i = 0; i < 1500; i++) begin
            r_op = 3'($urandom_range(0, 7));
            sel  = $urandom_range(0, 19);
            if (sel < 16)       r_addr = 32'($urandom_range(0, 63));
            else if (sel < 18)  r_addr = 32'($urandom_range(4088, 4103));
            else if (sel == 18) r_addr = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else                r_addr = $urandom;
            access("rnd", r_op, r_addr, $urandom, 1'($urandom_range(0, 1)));
        end

        // one reset in the middle of random contents, then re-check a window
        do_reset(1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 16; i++) begin
            access("post_rst", MEM_W, 32'(4 * i), 32'h0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
